// File: rtl/conv_mem_sequencer.sv
// conv_mem_sequencer: line-buffer ring sequencer for an N-lane, K-row convolver.
// Generates bank write/read addresses, routes bank words to the lanes and
// serialises the N lane results onto one output stream.
// Optional build macro MCU_SIGN_EXT_EN: sign-extend pixels into bank words
// (default build zero-extends).
module conv_mem_sequencer #(
  parameter int N           = 16,
  parameter int K           = 3,
  parameter int BITS_IMAGEN = 8,
  parameter int BITS_DATA   = 13,
  parameter int BITS_ADDR   = 10
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_sop,
  input  logic                           i_eop,
  input  logic                           i_chblk,
  input  logic [BITS_ADDR-1:0]           i_cols,
  input  logic                           i_valid,
  input  logic [BITS_IMAGEN-1:0]         i_Data,
  input  logic [(N+K-1)*BITS_DATA-1:0]   i_MemData,
  input  logic                           i_res_valid,
  input  logic [N*BITS_DATA-1:0]         i_DataConv,
  output logic                           o_ready,
  output logic [N+K-2:0]                 o_we,
  output logic [BITS_ADDR-1:0]           o_WAddr,
  output logic [(N+K-1)*BITS_DATA-1:0]   o_MemData,
  output logic [BITS_ADDR-1:0]           o_RAddr,
  output logic [K*N*BITS_IMAGEN-1:0]     o_DataConv,
  output logic                           o_conv_valid,
  output logic [BITS_DATA-1:0]           o_Data,
  output logic                           o_data_valid,
  output logic                           o_ovf,
  output logic [1:0]                     o_state
);

  localparam int NB  = N + K - 1;
  localparam int NBW = $clog2(NB);
  localparam int CW  = NBW + 1;
  localparam int SCW = $clog2(N + 1);

  localparam logic [BITS_ADDR-1:0] ADDR_ONE  = BITS_ADDR'(1);
  localparam logic [NBW-1:0]       BANK_ONE  = NBW'(1);
  localparam logic [NBW-1:0]       BANK_LAST = NBW'(NB - 1);
  localparam logic [NB-1:0]        BANK_BIT0 = {{(NB-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]        CNT_ONE   = CW'(1);
  localparam logic [CW-1:0]        NB_CNT    = CW'(NB);
  localparam logic [CW-1:0]        N_CNT     = CW'(N);
  localparam logic [SCW-1:0]       SER_ONE   = SCW'(1);
  localparam logic [SCW-1:0]       SER_LOAD  = SCW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CONV = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                      state_r, state_s;
  logic [BITS_ADDR-1:0]        cols_r, cols_s;
  logic [BITS_ADDR-1:0]        wcol_r, wcol_s;
  logic [BITS_ADDR-1:0]        rcol_r, rcol_s;
  logic [NBW-1:0]              wr_bank_r, wr_bank_s;
  logic [NBW-1:0]              base_r, base_s;
  logic [CW-1:0]               rows_r, rows_s;
  logic [CW-1:0]               need_r, need_s;
  logic                        eop_pend_r, eop_pend_s;

  logic [NB-1:0]               we_s;
  logic [BITS_ADDR-1:0]        waddr_s;
  logic [BITS_ADDR-1:0]        raddr_s;
  logic [NB*BITS_DATA-1:0]     wdata_s;
  logic                        rd_issue_s;

  logic [BITS_DATA-1:0]        pix_ext_s;
  logic [BITS_ADDR-1:0]        last_col_s;
  logic [CW-1:0]               rows_inc_s;
  logic [CW-1:0]               base_sum_s;
  logic [NBW-1:0]              bank_inc_s;
  logic [NBW-1:0]              base_adv_s;

  // read pipeline: issue stage and memory stage, each carrying the ring base
  logic                        rd_v0_r, rd_v1_r;
  logic [NBW-1:0]              rbase0_r, rbase1_r;

  logic [N*BITS_DATA-1:0]      sbuf_r;
  logic [SCW-1:0]              scnt_r;

  // Route bank words to lane rows: lane j row r reads bank (first+j+r) mod NB.
  function automatic logic [K*N*BITS_IMAGEN-1:0] gather_rows(
    input logic [NB*BITS_DATA-1:0] words,
    input logic [NBW-1:0]          first_bank
  );
    logic [K*N*BITS_IMAGEN-1:0] rows_out;
    int bank;
    rows_out = '0;
    for (int j = 0; j < N; j++) begin
      for (int r = 0; r < K; r++) begin
        bank = int'(first_bank) + j + r;
        if (bank >= NB) begin
          bank = bank - NB;
        end else begin
          bank = bank + 0;
        end
        rows_out[(j*K+r)*BITS_IMAGEN +: BITS_IMAGEN] = words[bank*BITS_DATA +: BITS_IMAGEN];
      end
    end
    return rows_out;
  endfunction

  assign o_state = state_r;

  // Pixel extension and the modular ring arithmetic shared by the FSM.
  always_comb begin
`ifdef MCU_SIGN_EXT_EN
    pix_ext_s = {{(BITS_DATA-BITS_IMAGEN){i_Data[BITS_IMAGEN-1]}}, i_Data};
`else
    pix_ext_s = {{(BITS_DATA-BITS_IMAGEN){1'b0}}, i_Data};
`endif
    last_col_s = cols_r - ADDR_ONE;
    rows_inc_s = rows_r + CNT_ONE;
    base_sum_s = {1'b0, base_r} + N_CNT;
    if (wr_bank_r == BANK_LAST) begin
      bank_inc_s = '0;
    end else begin
      bank_inc_s = wr_bank_r + BANK_ONE;
    end
    if (base_sum_s >= NB_CNT) begin
      base_adv_s = NBW'(base_sum_s - NB_CNT);
    end else begin
      base_adv_s = base_sum_s[NBW-1:0];
    end
  end

  // Next-state, ring counters and next values of the memory-side outputs.
  always_comb begin
    state_s    = state_r;
    cols_s     = cols_r;
    wcol_s     = wcol_r;
    rcol_s     = rcol_r;
    wr_bank_s  = wr_bank_r;
    base_s     = base_r;
    rows_s     = rows_r;
    need_s     = need_r;
    eop_pend_s = eop_pend_r;
    we_s       = '0;
    waddr_s    = o_WAddr;
    wdata_s    = o_MemData;
    raddr_s    = o_RAddr;
    rd_issue_s = 1'b0;
    if (i_chblk && (state_r != IDLE)) begin
      // abandon the block: restart the ring from bank 0 with a full fill
      state_s    = LOAD;
      wr_bank_s  = '0;
      base_s     = '0;
      rows_s     = '0;
      wcol_s     = '0;
      rcol_s     = '0;
      need_s     = NB_CNT;
      eop_pend_s = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (i_sop) begin
            state_s    = LOAD;
            wr_bank_s  = '0;
            base_s     = '0;
            rows_s     = '0;
            wcol_s     = '0;
            rcol_s     = '0;
            need_s     = NB_CNT;
            eop_pend_s = 1'b0;
            if (i_cols == '0) begin
              cols_s = ADDR_ONE;
            end else begin
              cols_s = i_cols;
            end
          end else begin
            state_s = IDLE;
          end
        end
        LOAD: begin
          if (i_eop) begin
            // partial row is discarded; the next image restarts everything
            state_s = IDLE;
          end else if (i_valid && o_ready) begin
            we_s    = BANK_BIT0 << wr_bank_r;
            waddr_s = wcol_r;
            wdata_s = {NB{pix_ext_s}};
            if (wcol_r == last_col_s) begin
              wcol_s    = '0;
              wr_bank_s = bank_inc_s;
              if (rows_inc_s == need_r) begin
                state_s = CONV;
                rows_s  = '0;
                rcol_s  = '0;
              end else begin
                rows_s = rows_inc_s;
              end
            end else begin
              wcol_s = wcol_r + ADDR_ONE;
            end
          end else begin
            state_s = LOAD;
          end
        end
        CONV: begin
          raddr_s    = rcol_r;
          rd_issue_s = 1'b1;
          if (rcol_r == last_col_s) begin
            // lanes advance by N banks; only N fresh rows are needed next time
            rcol_s     = '0;
            base_s     = base_adv_s;
            need_s     = N_CNT;
            rows_s     = '0;
            eop_pend_s = 1'b0;
            if (i_eop || eop_pend_r) begin
              state_s = DONE;
            end else begin
              state_s = LOAD;
            end
          end else begin
            rcol_s     = rcol_r + ADDR_ONE;
            eop_pend_s = eop_pend_r | i_eop;
          end
        end
        DONE: begin
          state_s = IDLE;
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Ring counters, memory-side outputs and the two-stage read pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      cols_r       <= ADDR_ONE;
      wcol_r       <= '0;
      rcol_r       <= '0;
      wr_bank_r    <= '0;
      base_r       <= '0;
      rows_r       <= '0;
      need_r       <= NB_CNT;
      eop_pend_r   <= 1'b0;
      o_ready      <= 1'b0;
      o_we         <= '0;
      o_WAddr      <= '0;
      o_MemData    <= '0;
      o_RAddr      <= '0;
      rd_v0_r      <= 1'b0;
      rd_v1_r      <= 1'b0;
      rbase0_r     <= '0;
      rbase1_r     <= '0;
      o_conv_valid <= 1'b0;
      o_DataConv   <= '0;
    end else begin
      cols_r       <= cols_s;
      wcol_r       <= wcol_s;
      rcol_r       <= rcol_s;
      wr_bank_r    <= wr_bank_s;
      base_r       <= base_s;
      rows_r       <= rows_s;
      need_r       <= need_s;
      eop_pend_r   <= eop_pend_s;
      o_ready      <= (state_s == LOAD);
      o_we         <= we_s;
      o_WAddr      <= waddr_s;
      o_MemData    <= wdata_s;
      o_RAddr      <= raddr_s;
      rd_v0_r      <= rd_issue_s;
      rbase0_r     <= base_r;
      rd_v1_r      <= rd_v0_r;
      rbase1_r     <= rbase0_r;
      o_conv_valid <= rd_v1_r;
      if (rd_v1_r) begin
        o_DataConv <= gather_rows(i_MemData, rbase1_r);
      end else begin
        o_DataConv <= o_DataConv;
      end
    end
  end

  // Result serialiser: one lane per cycle, sticky overflow when busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      sbuf_r       <= '0;
      scnt_r       <= '0;
      o_Data       <= '0;
      o_data_valid <= 1'b0;
      o_ovf        <= 1'b0;
    end else if (scnt_r == '0) begin
      if (i_res_valid) begin
        o_Data       <= i_DataConv[BITS_DATA-1:0];
        o_data_valid <= 1'b1;
        sbuf_r       <= i_DataConv >> BITS_DATA;
        scnt_r       <= SER_LOAD;
      end else begin
        o_data_valid <= 1'b0;
      end
    end else begin
      o_Data       <= sbuf_r[BITS_DATA-1:0];
      o_data_valid <= 1'b1;
      sbuf_r       <= sbuf_r >> BITS_DATA;
      scnt_r       <= scnt_r - SER_ONE;
      if (i_res_valid) begin
        o_ovf <= 1'b1;
      end else begin
        o_ovf <= o_ovf;
      end
    end
  end

endmodule

// File: tb/tb_conv_mem_sequencer.sv
// Self-checking bench for conv_mem_sequencer (N=4, K=3, NB=6, cols=5).
// Bank contents are modelled as a bank/column array filled by the ring rule
// "row number mod NB"; lane rows are (base + lane + row) mod NB.
module tb_conv_mem_sequencer;

  localparam int N = 4, K = 3, NB = 6, BI = 8, BD = 13, BA = 10, COLS = 5;
`ifdef MCU_SIGN_EXT_EN
  localparam logic [12:0] SEXT_EXP = 13'h1F80;
`else
  localparam logic [12:0] SEXT_EXP = 13'h0080;
`endif

  logic clk = 1'b0;
  logic rst, i_sop, i_eop, i_chblk, i_valid, i_res_valid;
  logic [BA-1:0]      i_cols;
  logic [BI-1:0]      i_Data;
  logic [NB*BD-1:0]   mem_rd;
  logic [N*BD-1:0]    i_DataConv;
  logic               o_ready, o_conv_valid, o_data_valid, o_ovf;
  logic [NB-1:0]      o_we;
  logic [BA-1:0]      o_WAddr, o_RAddr;
  logic [NB*BD-1:0]   o_MemData;
  logic [K*N*BI-1:0]  o_DataConv;
  logic [BD-1:0]      o_Data;
  logic [1:0]         o_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [BI-1:0] ref_mem [NB][COLS];
  int m_cols, m_col, m_rows, m_seg, m_need, m_base;

  logic [BD-1:0] bram [NB][1024];

  conv_mem_sequencer #(.N(N), .K(K), .BITS_IMAGEN(BI), .BITS_DATA(BD), .BITS_ADDR(BA)) dut (
    .clk(clk), .rst(rst), .i_sop(i_sop), .i_eop(i_eop), .i_chblk(i_chblk),
    .i_cols(i_cols), .i_valid(i_valid), .i_Data(i_Data), .i_MemData(mem_rd),
    .i_res_valid(i_res_valid), .i_DataConv(i_DataConv), .o_ready(o_ready),
    .o_we(o_we), .o_WAddr(o_WAddr), .o_MemData(o_MemData), .o_RAddr(o_RAddr),
    .o_DataConv(o_DataConv), .o_conv_valid(o_conv_valid), .o_Data(o_Data),
    .o_data_valid(o_data_valid), .o_ovf(o_ovf), .o_state(o_state)
  );

  always #5 clk = ~clk;

  // Line-buffer BRAMs: write on o_we, synchronous one-cycle read.
  always @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (o_we[b]) bram[b][o_WAddr] <= o_MemData[b*BD +: BD];
      mem_rd[b*BD +: BD] <= bram[b][o_RAddr];
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [12:0] ext13(input logic [7:0] p);
`ifdef MCU_SIGN_EXT_EN
    return {{5{p[7]}}, p};
`else
    return {5'b00000, p};
`endif
  endfunction

  function automatic logic [K*N*BI-1:0] exp_conv(input int col);
    logic [K*N*BI-1:0] e;
    e = '0;
    for (int j = 0; j < N; j++)
      for (int r = 0; r < K; r++)
        e[(j*K+r)*BI +: BI] = ref_mem[(m_base + j + r) % NB][col];
    return e;
  endfunction

  task automatic model_restart(input int cols);
    m_cols = cols; m_col = 0; m_rows = 0; m_seg = 0; m_need = NB; m_base = 0;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_state"}, 128'(o_state), 128'(0));
    chk({tag, "_ready"}, 128'(o_ready), 128'(0));
    chk({tag, "_we"}, 128'(o_we), 128'(0));
    chk({tag, "_waddr"}, 128'(o_WAddr), 128'(0));
    chk({tag, "_raddr"}, 128'(o_RAddr), 128'(0));
    chk({tag, "_wdata"}, 128'(o_MemData), 128'(0));
    chk({tag, "_conv"}, 128'(o_DataConv), 128'(0));
    chk({tag, "_cvalid"}, 128'(o_conv_valid), 128'(0));
    chk({tag, "_dvalid"}, 128'(o_data_valid), 128'(0));
    chk({tag, "_ovf"}, 128'(o_ovf), 128'(0));
    chk({tag, "_data"}, 128'(o_Data), 128'(0));
  endtask

  task automatic write_pixel(input logic [7:0] px);
    int bank;
    int exp_state;
    logic [12:0] w;
    bank = m_rows % NB;
    i_valid = 1'b1; i_Data = px;
    tick();
    i_valid = 1'b0;
    w = ext13(px);
    chk("wr_we", 128'(o_we), 128'd1 << bank);
    chk("wr_addr", 128'(o_WAddr), 128'(m_col));
    chk("wr_data", 128'(o_MemData), 128'({NB{w}}));
    ref_mem[bank][m_col] = px;
    exp_state = 1;
    m_col++;
    if (m_col == m_cols) begin
      m_col = 0; m_rows++; m_seg++;
      if (m_seg == m_need) begin
        m_seg = 0; exp_state = 2;
      end
    end
    chk("wr_state", 128'(o_state), 128'(exp_state));
  endtask

  task automatic conv_pass(input bit with_eop);
    for (int t = 0; t < 8; t++) begin
      i_eop = with_eop && (t == 1);
      tick();
      i_eop = 1'b0;
      if (t < 5) chk("raddr", 128'(o_RAddr), 128'(t));
      if (t < 4) chk("cv_state", 128'(o_state), 128'(2));
      if (t == 4) chk("post_state", 128'(o_state), with_eop ? 128'(3) : 128'(1));
      if (t == 5 && with_eop) chk("done_len", 128'(o_state), 128'(0));
      if (t >= 2 && t < 7) begin
        chk("cv_valid", 128'(o_conv_valid), 128'(1));
        chk("cv_data", 128'(o_DataConv), 128'(exp_conv(t - 2)));
      end else begin
        chk("cv_idle", 128'(o_conv_valid), 128'(0));
      end
    end
    m_base = (m_base + N) % NB;
    m_need = N;
  endtask

  initial begin
    logic [12:0] ra [N];
    logic [12:0] rb [N];
    rst = 1'b1; i_sop = 1'b0; i_eop = 1'b0; i_chblk = 1'b0; i_valid = 1'b0;
    i_res_valid = 1'b0; i_cols = '0; i_Data = '0; i_DataConv = '0;
    model_restart(COLS);
    tick(); tick();
    reset_checks("por");
    rst = 1'b0;
    tick();
    chk("idle_hold", 128'(o_state), 128'(0));

    // Fill: bank b column c holds 10*b+c
    i_sop = 1'b1; i_cols = BA'(COLS);
    tick();
    i_sop = 1'b0;
    model_restart(COLS);
    chk("sop_state", 128'(o_state), 128'(1));
    chk("sop_ready", 128'(o_ready), 128'(1));
    for (int i = 0; i < 6 * COLS; i++) write_pixel(8'(10 * (i / COLS) + i % COLS));
    chk("conv_ready", 128'(o_ready), 128'(0));
    conv_pass(1'b0);

    // Wrap: four random rows into banks 0..3 with random gaps
    for (int i = 0; i < 4 * COLS; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        tick();
        chk("gap_we", 128'(o_we), 128'(0));
      end
      write_pixel(8'($urandom));
    end
    conv_pass(1'b1);

    // Serialiser: a burst, then another accepted on its last word
    for (int l = 0; l < N; l++) begin
      ra[l] = 13'($urandom); rb[l] = 13'($urandom);
    end
    i_DataConv = {ra[3], ra[2], ra[1], ra[0]}; i_res_valid = 1'b1;
    tick();
    i_res_valid = 1'b0;
    for (int k = 0; k < N; k++) begin
      chk("serA_v", 128'(o_data_valid), 128'(1));
      chk("serA_d", 128'(o_Data), 128'(ra[k]));
      if (k == N - 1) begin
        i_DataConv = {rb[3], rb[2], rb[1], rb[0]}; i_res_valid = 1'b1;
      end
      tick();
      i_res_valid = 1'b0;
    end
    for (int k = 0; k < N; k++) begin
      chk("serB_v", 128'(o_data_valid), 128'(1));
      chk("serB_d", 128'(o_Data), 128'(rb[k]));
      tick();
    end
    chk("ser_idle", 128'(o_data_valid), 128'(0));
    chk("ser_noovf", 128'(o_ovf), 128'(0));
    i_DataConv = {13'd4, 13'd3, 13'd2, 13'd1}; i_res_valid = 1'b1;
    tick();
    i_res_valid = 1'b0;
    chk("ser_w1", 128'(o_Data), 128'(1));
    tick();
    chk("ser_w2", 128'(o_Data), 128'(2));
    i_DataConv = {ra[0], rb[1], ra[2], rb[3]}; i_res_valid = 1'b1;
    tick();
    i_res_valid = 1'b0;
    chk("ser_w3", 128'(o_Data), 128'(3));
    chk("ovf_set", 128'(o_ovf), 128'(1));
    tick();
    chk("ser_w4", 128'(o_Data), 128'(4));
    tick();
    chk("ser_drop", 128'(o_data_valid), 128'(0));
    chk("ovf_sticky", 128'(o_ovf), 128'(1));

    // Change-block mid-CONV restarts the ring at bank 0 column 0
    i_sop = 1'b1;
    tick();
    i_sop = 1'b0;
    model_restart(COLS);
    for (int i = 0; i < 6 * COLS; i++) write_pixel(8'($urandom));
    tick(); tick();
    i_chblk = 1'b1;
    tick();
    i_chblk = 1'b0;
    chk("chblk_state", 128'(o_state), 128'(1));
    chk("chblk_ready", 128'(o_ready), 128'(1));
    model_restart(COLS);
    for (int i = 0; i < 3; i++) write_pixel(8'($urandom));

    // End of image mid-LOAD, then ignored in IDLE
    i_eop = 1'b1;
    tick();
    i_eop = 1'b0;
    chk("eop_state", 128'(o_state), 128'(0));
    chk("eop_ready", 128'(o_ready), 128'(0));
    i_eop = 1'b1;
    tick();
    i_eop = 1'b0;
    chk("eop_idle", 128'(o_state), 128'(0));

    // cols==0 behaves as one column; extension of 8'h80
    i_sop = 1'b1; i_cols = '0;
    tick();
    i_sop = 1'b0;
    model_restart(1);
    chk("c0_state", 128'(o_state), 128'(1));
    write_pixel(8'h80);
    chk("ext_word", 128'(o_MemData[12:0]), 128'(SEXT_EXP));
    write_pixel(8'($urandom));

    // Reset mid-LOAD with a pixel offered
    i_valid = 1'b1; i_Data = 8'h55; rst = 1'b1;
    tick();
    rst = 1'b0; i_valid = 1'b0;
    reset_checks("rst_load");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
